controlador_decodificador_hamming: RTL and testbench

Sequencing controller for the 8-bit SECDED Hamming receive path. It accepts codewords in the layout [p0,i3,i2,i1,c2,i0,c1,c0] over a valid/ready handshake. For each word it registers the codeword, computes the syndrome and the global parity, applies single-bit correction and extracts the 4 data bits. It presents the result with an error status and keeps saturating error-event counters for the display/LED logic downstream.

---
 rtl/hamming_pkg.sv | 32 +++
 rtl/controlador_decodificador_hamming_calculo_sindrome.sv | 16 +
 rtl/controlador_decodificador_hamming.sv | 142 ++++++++++++++
 tb/tb_controlador_decodificador_hamming.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and codeword bit layout for the 8-bit SECDED Hamming receive path.
// Layout (MSB..LSB): [p0,i3,i2,i1,c2,i0,c1,c0].
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        CORRECT = 2'd2,
        OUTPUT  = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        ST_OK     = 2'b00,
        ST_SINGLE = 2'b01,
        ST_DOUBLE = 2'b10,
        ST_P0     = 2'b11
    } status_t;

    localparam int P0_IDX = 7;
    localparam int I3_IDX = 6;
    localparam int I2_IDX = 5;
    localparam int I1_IDX = 4;
    localparam int C2_IDX = 3;
    localparam int I0_IDX = 2;
    localparam int C1_IDX = 1;
    localparam int C0_IDX = 0;

    function automatic logic [3:0] extraer_datos(input logic [7:0] palabra);
        return {palabra[I3_IDX], palabra[I2_IDX], palabra[I1_IDX], palabra[I0_IDX]};
    endfunction

endpackage

// File: rtl/controlador_decodificador_hamming_calculo_sindrome.sv
// Combinational syndrome and global even-parity computation for one codeword.
module calculo_sindrome
    import hamming_pkg::*;
(
    input  logic [7:0] palabra_i,
    output logic [2:0] sindrome_o,
    output logic       paridad_o
);

    // Syndrome value k (1..7) points at codeword bit k-1.
    assign sindrome_o[0] = palabra_i[C0_IDX] ^ palabra_i[I0_IDX] ^ palabra_i[I1_IDX] ^ palabra_i[I3_IDX];
    assign sindrome_o[1] = palabra_i[C1_IDX] ^ palabra_i[I0_IDX] ^ palabra_i[I2_IDX] ^ palabra_i[I3_IDX];
    assign sindrome_o[2] = palabra_i[C2_IDX] ^ palabra_i[I1_IDX] ^ palabra_i[I2_IDX] ^ palabra_i[I3_IDX];
    assign paridad_o     = ^palabra_i;

endmodule

// File: rtl/controlador_decodificador_hamming.sv
// Sequencing controller: capture, syndrome check, single-bit correction and result
// hand-off for SECDED codewords, with saturating error-event counters.
module controlador_decodificador_hamming
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_codeword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_codeword,
    output logic [3:0]       out_data,
    output logic [2:0]       out_sindrome,
    output logic [1:0]       out_status,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double
);

    estado_t          estado_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [7:0]       palabra_q;
    logic [2:0]       sind_q;
    logic             gp_q;
    logic [7:0]       out_codeword_q;
    logic [3:0]       out_data_q;
    logic [2:0]       out_sind_q;
    status_t          out_status_q;
    logic [CNT_W-1:0] cnt_single_q;
    logic [CNT_W-1:0] cnt_double_q;

    logic [2:0] sind_w;
    logic       gp_w;
    logic [7:0] corr_d;
    status_t    status_d;
    logic       handshake;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    calculo_sindrome u_sindrome (
        .palabra_i  (palabra_q),
        .sindrome_o (sind_w),
        .paridad_o  (gp_w)
    );

    always_comb begin
        corr_d   = palabra_q;
        status_d = ST_OK;
        if (sind_q == 3'd0) begin
            if (gp_q) begin
                corr_d[P0_IDX] = ~palabra_q[P0_IDX];
                status_d       = ST_P0;
            end
        end else if (gp_q) begin
            corr_d   = palabra_q ^ (8'd1 << (sind_q - 3'd1));
            status_d = ST_SINGLE;
        end else begin
            status_d = ST_DOUBLE;
        end
    end

    assign handshake = (estado_q == OUTPUT) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q       <= IDLE;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            palabra_q      <= '0;
            sind_q         <= '0;
            gp_q           <= 1'b0;
            out_codeword_q <= '0;
            out_data_q     <= '0;
            out_sind_q     <= '0;
            out_status_q   <= ST_OK;
        end else begin
            case (estado_q)
                IDLE: begin
                    if (in_valid) begin
                        palabra_q  <= in_codeword;
                        in_ready_q <= 1'b0;
                        estado_q   <= CHECK;
                    end
                end
                CHECK: begin
                    sind_q   <= sind_w;
                    gp_q     <= gp_w;
                    estado_q <= CORRECT;
                end
                CORRECT: begin
                    out_codeword_q <= corr_d;
                    out_data_q     <= extraer_datos(corr_d);
                    out_sind_q     <= sind_q;
                    out_status_q   <= status_d;
                    out_valid_q    <= 1'b1;
                    estado_q       <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        estado_q    <= IDLE;
                    end
                end
                default: estado_q <= IDLE;
            endcase
        end
    end

    // Counters advance on the result handshake; a simultaneous clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else if (clr_cnt) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else if (handshake) begin
            if (out_status_q == ST_SINGLE || out_status_q == ST_P0)
                cnt_single_q <= sat_inc(cnt_single_q);
            else if (out_status_q == ST_DOUBLE)
                cnt_double_q <= sat_inc(cnt_double_q);
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_codeword = out_codeword_q;
    assign out_data     = out_data_q;
    assign out_sindrome = out_sind_q;
    assign out_status   = out_status_q;
    assign cnt_single   = cnt_single_q;
    assign cnt_double   = cnt_double_q;

endmodule

// File: tb/tb_controlador_decodificador_hamming.sv
// Directed bench for the Hamming receive controller, counters sized to 2 bits.
module tb_controlador_decodificador_hamming;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_codeword;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_codeword;
    logic [3:0]       out_data;
    logic [2:0]       out_sindrome;
    logic [1:0]       out_status;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_single;
    logic [CNT_W-1:0] cnt_double;

    int n_tests = 0;
    int n_fail  = 0;

    controlador_decodificador_hamming #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_codeword  (in_codeword),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
        .out_data     (out_data),
        .out_sindrome (out_sindrome),
        .out_status   (out_status),
        .clr_cnt      (clr_cnt),
        .cnt_single   (cnt_single),
        .cnt_double   (cnt_double)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_tests++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Presents a word, waits for acceptance and returns edges from accept to out_valid.
    task automatic enviar(input logic [7:0] w, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        in_codeword = w;
        in_valid    = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chequear("in_ready_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic procesar(input string tag, input logic [7:0] w, input logic [7:0] cw,
                            input logic [3:0] dat, input logic [2:0] sin, input logic [1:0] st,
                            input logic [CNT_W-1:0] cs, input logic [CNT_W-1:0] cd);
        int lat;
        enviar(w, lat);
        chequear({tag, "_lat"}, lat, 32'd2);
        chequear({tag, "_cw"}, out_codeword, cw);
        chequear({tag, "_data"}, out_data, dat);
        chequear({tag, "_sind"}, out_sindrome, sin);
        chequear({tag, "_status"}, out_status, st);
        @(posedge clk);
        #1;
        chequear({tag, "_vld_drop"}, out_valid, 32'd0);
        chequear({tag, "_cnt_s"}, cnt_single, cs);
        chequear({tag, "_cnt_d"}, cnt_double, cd);
    endtask

    initial begin
        int lat;
        logic [7:0] snap_cw;
        logic [1:0] snap_st;

        rst = 1'b1; in_valid = 1'b0; in_codeword = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chequear("rst_in_ready", in_ready, 32'd1);
        chequear("rst_out_valid", out_valid, 32'd0);
        chequear("rst_cw", out_codeword, 32'd0);
        chequear("rst_status", out_status, 32'd0);
        chequear("rst_cnt_s", cnt_single, 32'd0);
        chequear("rst_cnt_d", cnt_double, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        procesar("clean",  8'h55, 8'h55, 4'b1011, 3'b000, 2'b00, 2'd0, 2'd0);
        procesar("single", 8'h45, 8'h55, 4'b1011, 3'b101, 2'b01, 2'd1, 2'd0);
        procesar("p0",     8'hD5, 8'h55, 4'b1011, 3'b000, 2'b11, 2'd2, 2'd0);
        procesar("double", 8'h56, 8'h56, 4'b1011, 3'b011, 2'b10, 2'd2, 2'd1);

        // Backpressure with an intruding word on in_valid
        out_ready = 1'b0;
        enviar(8'h55, lat);
        chequear("bp_lat", lat, 32'd2);
        snap_cw = out_codeword;
        snap_st = out_status;
        chequear("bp_cw", snap_cw, 32'h55);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chequear("bp_hold_valid", out_valid, 32'd1);
            chequear("bp_hold_cw", out_codeword, snap_cw);
            chequear("bp_hold_st", out_status, snap_st);
            chequear("bp_in_ready", in_ready, 32'd0);
            in_codeword = 8'hAA;
            in_valid    = (i % 2 == 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chequear("bp_release_vld", out_valid, 32'd0);
        chequear("bp_release_rdy", in_ready, 32'd1);
        procesar("after_bp", 8'hAA, 8'hAA, 4'b0100, 3'b000, 2'b00, 2'd2, 2'd1);

        // Saturation of cnt_single at 3
        for (int i = 0; i < 5; i++) begin
            procesar("sat", 8'h45, 8'h55, 4'b1011, 3'b101, 2'b01, 2'd3, 2'd1);
        end

        // Clear on the same edge as a double-error handshake
        out_ready = 1'b0;
        enviar(8'h56, lat);
        chequear("clr_status", out_status, 32'd2);
        @(negedge clk);
        clr_cnt   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chequear("clr_cnt_d", cnt_double, 32'd0);
        chequear("clr_cnt_s", cnt_single, 32'd0);

        procesar("pre_rst", 8'h45, 8'h55, 4'b1011, 3'b101, 2'b01, 2'd1, 2'd0);

        // Reset while the word sits in CORRECT
        @(negedge clk);
        in_codeword = 8'h56;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chequear("mid_rst_vld", out_valid, 32'd0);
        chequear("mid_rst_rdy", in_ready, 32'd1);
        chequear("mid_rst_cw", out_codeword, 32'd0);
        chequear("mid_rst_data", out_data, 32'd0);
        chequear("mid_rst_cnt_s", cnt_single, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        procesar("post_rst", 8'h55, 8'h55, 4'b1011, 3'b000, 2'b00, 2'd0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
